// File: rtl/branch_resolve_unit_if.sv
// Request/response bundle for the branch resolve unit.
// The master drives requests and out_ready; the slave is the unit.
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            pred_taken;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_next_pc;
  logic            out_mispredict;
  logic            out_illegal;
  logic            out_misalign;

  modport master (
    output in_valid,
    output instr,
    output pc,
    output rs1,
    output rs2,
    output pred_taken,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_taken,
    input  out_next_pc,
    input  out_mispredict,
    input  out_illegal,
    input  out_misalign
  );

  modport slave (
    input  in_valid,
    input  instr,
    input  pc,
    input  rs1,
    input  rs2,
    input  pred_taken,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_taken,
    output out_next_pc,
    output out_mispredict,
    output out_illegal,
    output out_misalign
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Pipelined B-type branch resolver: compare, next PC, mispredict flags.
// Optional retirement statistics under macro BRU_STATS_EN.
module branch_resolve_unit #(
  parameter int XLEN    = 32,
  parameter int STAGES  = 1,
  parameter int C_EXT   = 0,
  parameter int COUNT_W = 32
) (
  input  logic clk,
  input  logic rst,
  branch_resolve_unit_if.slave bus
`ifdef BRU_STATS_EN
  ,
  output logic [COUNT_W-1:0] taken_cnt,
  output logic [COUNT_W-1:0] mispred_cnt
`endif
);

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] next_pc;
    logic            mispredict;
    logic            illegal;
    logic            misalign;
  } bru_res_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [2:0]      funct3;
  logic [6:0]      opcode;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] seq_pc;

  logic is_beq;
  logic is_bne;
  logic is_blt;
  logic is_bge;
  logic is_bltu;
  logic is_bgeu;

  logic cmp_eq;
  logic cmp_lt;
  logic cmp_ltu;
  logic cond;
  logic bad_op;
  logic bad_f3;
  logic illegal;
  logic taken;
  logic tgt_bad;

  bru_res_t res_d;

  bru_res_t        data_q [STAGES];
  logic [STAGES-1:0] vld_q;

  logic adv;
  logic unused_instr;

  assign unused_instr = ^bus.instr[24:15];

  assign funct3 = bus.instr[14:12];
  assign opcode = bus.instr[6:0];

  // Field extraction, immediate and raw comparisons.
  always_comb begin
    imm = {{(XLEN-12){bus.instr[31]}},
           bus.instr[7],
           bus.instr[30:25],
           bus.instr[11:8],
           1'b0};
    target  = bus.pc + imm;
    seq_pc  = bus.pc + XLEN'(4);
    cmp_eq  = (bus.rs1 == bus.rs2);
    cmp_lt  = ($signed(bus.rs1) < $signed(bus.rs2));
    cmp_ltu = (bus.rs1 < bus.rs2);
  end

  // One-hot funct3 decode.
  always_comb begin
    is_beq  = (funct3 == 3'b000);
    is_bne  = (funct3 == 3'b001);
    is_blt  = (funct3 == 3'b100);
    is_bge  = (funct3 == 3'b101);
    is_bltu = (funct3 == 3'b110);
    is_bgeu = (funct3 == 3'b111);
    bad_f3  = (funct3 == 3'b010) ||
              (funct3 == 3'b011);
    bad_op  = (opcode != OP_BRANCH);
  end

  // Select the branch condition for the decoded compare.
  always_comb begin
    cond = 1'b0;
    unique case (1'b1)
      is_beq:  cond = cmp_eq;
      is_bne:  cond = !cmp_eq;
      is_blt:  cond = cmp_lt;
      is_bge:  cond = !cmp_lt;
      is_bltu: cond = cmp_ltu;
      is_bgeu: cond = !cmp_ltu;
      default: cond = 1'b0;
    endcase
  end

  // Illegal forms never take and never mispredict.
  always_comb begin
    illegal = bad_op || bad_f3;
    taken   = cond && !illegal;
    if (C_EXT != 0) begin
      tgt_bad = target[0];
    end else begin
      tgt_bad = |target[1:0];
    end
    res_d.taken      = taken;
    res_d.next_pc    = taken ? target : seq_pc;
    res_d.illegal    = illegal;
    res_d.misalign   = taken && tgt_bad;
    res_d.mispredict = !illegal &&
                       (taken != bus.pred_taken);
  end

  assign adv          = bus.in_ready;
  assign bus.in_ready = !(bus.out_valid &&
                          !bus.out_ready);

  // Stage valids: flush wins, otherwise shift when not stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else if (bus.flush) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q[0] <= bus.in_valid;
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Stage payloads shift with the valids; held while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else if (adv) begin
      data_q[0] <= res_d;
      for (int i = 1; i < STAGES; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign bus.out_valid      = vld_q[STAGES-1];
  assign bus.out_taken      = data_q[STAGES-1].taken;
  assign bus.out_next_pc    = data_q[STAGES-1].next_pc;
  assign bus.out_mispredict = data_q[STAGES-1].mispredict;
  assign bus.out_illegal    = data_q[STAGES-1].illegal;
  assign bus.out_misalign   = data_q[STAGES-1].misalign;

`ifdef BRU_STATS_EN
  logic retire;

  assign retire = bus.out_valid &&
                  bus.out_ready &&
                  !bus.flush;

  // Saturating retirement counters; flushed entries never count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_cnt   <= '0;
      mispred_cnt <= '0;
    end else if (retire) begin
      if (bus.out_taken && (taken_cnt != '1)) begin
        taken_cnt <= taken_cnt + COUNT_W'(1);
      end
      if (bus.out_mispredict &&
          (mispred_cnt != '1)) begin
        mispred_cnt <= mispred_cnt + COUNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised and directed bench for branch_resolve_unit.
// Reference model derives results from the ISA rules directly.
module tb_branch_resolve_unit;
  localparam int XLEN   = 32;
  localparam int STAGES = 2;
`ifdef BRU_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 32;
`endif

  typedef struct packed {
    logic        taken;
    logic [31:0] npc;
    logic        mis;
    logic        ill;
    logic        mal;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(XLEN)) bus ();

`ifdef BRU_STATS_EN
  logic [CW-1:0] taken_cnt;
  logic [CW-1:0] mispred_cnt;
`endif

  branch_resolve_unit #(
    .XLEN(XLEN), .STAGES(STAGES),
    .C_EXT(0), .COUNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef BRU_STATS_EN
    ,
    .taken_cnt(taken_cnt),
    .mispred_cnt(mispred_cnt)
`endif
  );

  res_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   delivered = 0;
  bit   held = 0;
  res_t held_r;
  int   exp_tc = 0;
  int   exp_mc = 0;
  localparam int CMAX = (CW >= 31) ? 32'h7fffffff
                                   : ((1 << CW) - 1);

  function automatic res_t model(
    logic [31:0] ins, logic [31:0] pc,
    logic [31:0] a, logic [31:0] b, logic pred);
    res_t r;
    int f3;
    bit legal;
    bit t;
    longint sa, sb, ua, ub, imm;
    logic [31:0] tgt;
    f3 = int'(ins[14:12]);
    legal = (ins[6:0] == 7'h63) && f3 != 2 && f3 != 3;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[31] ? ua - 64'sh1_0000_0000 : ua;
    sb = b[31] ? ub - 64'sh1_0000_0000 : ub;
    imm = longint'({ins[31], ins[7], ins[30:25],
                    ins[11:8], 1'b0});
    if (imm >= 4096) imm = imm - 8192;
    case (f3)
      0: t = (ua == ub);
      1: t = (ua != ub);
      4: t = (sa < sb);
      5: t = (sa >= sb);
      6: t = (ua < ub);
      7: t = (ua >= ub);
      default: t = 0;
    endcase
    if (!legal) t = 0;
    tgt = 32'(longint'(pc) + imm);
    r.taken = t;
    r.npc = t ? tgt : 32'(longint'(pc) + 4);
    r.mal = t && (tgt % 4 != 0);
    r.ill = !legal;
    r.mis = legal && (t != pred);
    return r;
  endfunction

  function automatic logic [31:0] enc(
    logic [2:0] f3, logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1,
            f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic res_t dut_out();
    return {bus.out_taken, bus.out_next_pc,
            bus.out_mispredict, bus.out_illegal,
            bus.out_misalign};
  endfunction

  task automatic tick();
    res_t e;
    #1;
    if (held) begin
      checks++;
      if (bus.out_valid !== 1'b1 ||
          dut_out() !== held_r) begin
        errors++;
        $display("FAIL stall_stable: got v=%b %h exp v=1 %h",
                 bus.out_valid, dut_out(), held_r);
      end
    end
    held = 0;
    if (bus.out_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL spurious_out: got out_valid=1 exp 0");
      end else if (bus.out_ready === 1'b1) begin
        e = q.pop_front();
        checks++;
        if (dut_out() !== e) begin
          errors++;
          $display("FAIL result: got %h exp %h",
                   dut_out(), e);
        end
        delivered++;
        if (!bus.flush) begin
          if (e.taken && exp_tc < CMAX) exp_tc++;
          if (e.mis && exp_mc < CMAX) exp_mc++;
        end
      end else if (!bus.flush) begin
        held = 1;
        held_r = dut_out();
      end
    end
    if (bus.flush) q.delete();
    else if (bus.in_valid && bus.in_ready)
      q.push_back(model(bus.instr, bus.pc, bus.rs1,
                        bus.rs2, bus.pred_taken));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    q.delete();
    held = 0;
    exp_tc = 0;
    exp_mc = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_one(
    input logic [31:0] ins, input logic [31:0] pc,
    input logic [31:0] a, input logic [31:0] b,
    input logic pred, output res_t r, output int lat);
    bus.instr = ins;
    bus.pc = pc;
    bus.rs1 = a;
    bus.rs2 = b;
    bus.pred_taken = pred;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    forever begin
      #1;
      if (bus.out_valid === 1'b1 || lat >= 20) break;
      tick();
      lat++;
    end
    r = dut_out();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b exp 0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b exp 1", bus.in_ready);
    end
    checks++;
    if (dut_out() !== '0) begin
      errors++;
      $display("FAIL reset_fields: got %h exp 0", dut_out());
    end
`ifdef BRU_STATS_EN
    checks++;
    if (taken_cnt !== '0 || mispred_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d exp 0/0",
               taken_cnt, mispred_cnt);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_beq();
    res_t r;
    int lat;
    run_one(enc(3'b000, 13'd8), 32'h100, 32'd10, 32'd10,
            1'b0, r, lat);
    checks++;
    if (lat != STAGES) begin
      errors++;
      $display("FAIL beq_latency: got %0d exp %0d", lat, STAGES);
    end
    checks++;
    if (r.taken !== 1'b1 || r.npc !== 32'h108 ||
        r.mis !== 1'b1 || r.mal !== 1'b0) begin
      errors++;
      $display("FAIL beq: got %h exp t=1 npc=108 mis=1", r);
    end
  endtask

  task automatic test_signed_unsigned();
    res_t r;
    int lat;
    run_one(enc(3'b100, 13'd16), 32'h200, 32'hFFFFFFFF,
            32'd1, 1'b1, r, lat);
    checks++;
    if (r.taken !== 1'b1 || r.npc !== 32'h210 ||
        r.mis !== 1'b0) begin
      errors++;
      $display("FAIL blt: got %h exp t=1 npc=210", r);
    end
    run_one(enc(3'b110, 13'd16), 32'h200, 32'hFFFFFFFF,
            32'd1, 1'b1, r, lat);
    checks++;
    if (r.taken !== 1'b0 || r.npc !== 32'h204 ||
        r.mis !== 1'b1) begin
      errors++;
      $display("FAIL bltu: got %h exp t=0 npc=204", r);
    end
  endtask

  task automatic test_wrap();
    res_t r;
    int lat;
    run_one(enc(3'b000, 13'd8), 32'hFFFFFFFC, 32'd5,
            32'd5, 1'b1, r, lat);
    checks++;
    if (r.taken !== 1'b1 || r.npc !== 32'h4) begin
      errors++;
      $display("FAIL wrap_up: got %h exp npc=4", r);
    end
    run_one(enc(3'b000, 13'h1000), 32'h0, 32'd7,
            32'd7, 1'b1, r, lat);
    checks++;
    if (r.taken !== 1'b1 || r.npc !== 32'hFFFFF000) begin
      errors++;
      $display("FAIL wrap_down: got %h exp npc=fffff000", r);
    end
    run_one(enc(3'b000, 13'd2), 32'h100, 32'd1,
            32'd1, 1'b1, r, lat);
    checks++;
    if (r.mal !== 1'b1 || r.npc !== 32'h102 ||
        r.taken !== 1'b1) begin
      errors++;
      $display("FAIL misalign: got %h exp mal=1 npc=102", r);
    end
    run_one(enc(3'b001, 13'd2), 32'h100, 32'd1,
            32'd1, 1'b0, r, lat);
    checks++;
    if (r.mal !== 1'b0 || r.npc !== 32'h104) begin
      errors++;
      $display("FAIL misalign_nt: got %h exp mal=0 npc=104", r);
    end
  endtask

  task automatic test_illegal();
    res_t r;
    int lat;
    logic [31:0] ins;
    run_one(enc(3'b010, 13'd8), 32'h300, 32'd3,
            32'd3, 1'b1, r, lat);
    checks++;
    if (r.ill !== 1'b1 || r.taken !== 1'b0 ||
        r.npc !== 32'h304 || r.mis !== 1'b0 ||
        r.mal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_f3: got %h exp ill=1 npc=304", r);
    end
    ins = enc(3'b000, 13'd8);
    ins[6:0] = 7'h67;
    run_one(ins, 32'h400, 32'd3, 32'd3, 1'b1, r, lat);
    checks++;
    if (r.ill !== 1'b1 || r.taken !== 1'b0 ||
        r.npc !== 32'h404) begin
      errors++;
      $display("FAIL illegal_op: got %h exp ill=1 npc=404", r);
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int cyc = 0;
    int base = delivered;
    bit acc;
    while ((delivered - base) < 4 && cyc < 60) begin
      bus.out_ready = !(cyc >= STAGES && cyc < STAGES + 3);
      bus.in_valid = (sent < 4);
      bus.instr = enc(3'($urandom_range(4, 7)),
                      13'($urandom));
      bus.pc = $urandom & 32'hFFFF_FFFC;
      bus.rs1 = $urandom;
      bus.rs2 = $urandom;
      bus.pred_taken = 1'($urandom);
      #1;
      if (cyc >= STAGES && cyc < STAGES + 3) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
        begin
          errors++;
          $display("FAIL b2b_stall: got v=%b r=%b exp v=1 r=0",
                   bus.out_valid, bus.in_ready);
        end
      end
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) sent++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if ((delivered - base) != 4 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d exp 4",
               delivered - base);
    end
  endtask

  task automatic test_flush();
    res_t r;
    int lat;
    bus.out_ready = 1'b1;
    bus.instr = enc(3'b000, 13'd8);
    bus.pc = 32'h500;
    bus.rs1 = 1;
    bus.rs2 = 1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready: got %b exp 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_kill: got %b exp 0", bus.out_valid);
      end
      tick();
    end
    run_one(enc(3'b001, 13'd32), 32'h600, 32'd1, 32'd2,
            1'b1, r, lat);
    checks++;
    if (lat != STAGES || r.npc !== 32'h620 ||
        r.mis !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: got lat=%0d %h exp npc=620",
               lat, r);
    end
  endtask

  task automatic test_flush_stall();
    int n = 0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.instr = enc(3'b101, 13'd64);
    bus.pc = 32'h700;
    bus.rs1 = 9;
    bus.rs2 = 4;
    repeat (STAGES + 1) tick();
    bus.in_valid = 1'b0;
    while (bus.out_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %b exp 0", bus.out_valid);
    end
    bus.out_ready = 1'b1;
    repeat (STAGES + 2) tick();
  endtask

  task automatic test_random();
    logic [31:0] ins;
    int n = 0;
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      ins = enc(3'($urandom), 13'($urandom));
      if ($urandom % 10 == 0) ins[6:0] = 7'($urandom);
      bus.instr = ins;
      bus.pc = $urandom;
      bus.rs1 = ($urandom % 4 == 0) ? $urandom % 8
                                    : $urandom;
      bus.rs2 = ($urandom % 4 == 0) ? bus.rs1 : $urandom;
      bus.pred_taken = 1'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    while (q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL random_drain: got %0d left exp 0", q.size());
    end
  endtask

`ifdef BRU_STATS_EN
  task automatic test_stats();
    res_t r;
    int lat;
    checks++;
    if (int'(taken_cnt) != exp_tc ||
        int'(mispred_cnt) != exp_mc) begin
      errors++;
      $display("FAIL stats_run: got %0d/%0d exp %0d/%0d",
               taken_cnt, mispred_cnt, exp_tc, exp_mc);
    end
    do_reset();
    for (int i = 0; i < 5; i++)
      run_one(enc(3'b000, 13'd8), 32'h800, 32'd2,
              32'd2, 1'b0, r, lat);
    checks++;
    if (taken_cnt !== 2'd3 || mispred_cnt !== 2'd3) begin
      errors++;
      $display("FAIL stats_sat: got %0d/%0d exp 3/3",
               taken_cnt, mispred_cnt);
    end
  endtask
`endif

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.instr = enc(3'b000, 13'd8);
    bus.rs1 = 0;
    bus.rs2 = 0;
    tick();
    tick();
    bus.in_valid = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid: got %b exp 0", bus.out_valid);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush = 1'b0;
    bus.instr = '0;
    bus.pc = '0;
    bus.rs1 = '0;
    bus.rs2 = '0;
    bus.pred_taken = 1'b0;
    @(negedge clk);
    test_reset();
    test_beq();
    test_signed_unsigned();
    test_wrap();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_flush_stall();
    test_random();
`ifdef BRU_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
